cpu_idecode_q: RTL

- Sequential instruction decoder for the MCS8 (Intel 8008) CPU core.
- Consumes the fetched opcode byte stream through a valid/ready handshake.
- Assembles 1-, 2- and 3-byte instructions, decodes class and operand sources/destinations, and queues complete decoded instructions in a DEPTH-entry FIFO for the execute stage.
- Generalises the earlier combinational class decoder: adds immediate/address capture, back-pressure, queueing and flush.

---
 rtl/cpu_idecode_q.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_idecode_q.sv
// Purpose : MCS8 (8008) sequential instruction decoder with a DEPTH-entry decoded-instruction queue.
// Latency : an entry reaches D_VALID_O the cycle after its final byte is accepted.
// Backpress: B_READY_O drops while the queue is full or FLUSH_I is high; D_READY_I pops the head.
//
// Ports:
//   CLK_I, RST_N_I       clock (rising edge), asynchronous active-low reset
//   FLUSH_I              synchronous flush of the partial instruction and the queue
//   B_DATA_I/VALID/READY fetched byte stream (valid/ready)
//   D_VALID_O/D_READY_I  decoded head entry handshake
//   D_OPC/LEN/CLASS/SRC/DST/IMM/ADDR_O  head entry payload, all zero when D_VALID_O=0
module cpu_idecode_q #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 2
) (
  input  logic              CLK_I,
  input  logic              RST_N_I,
  input  logic              FLUSH_I,
  input  logic [7:0]        B_DATA_I,
  input  logic              B_VALID_I,
  output logic              B_READY_O,
  output logic              D_VALID_O,
  input  logic              D_READY_I,
  output logic [7:0]        D_OPC_O,
  output logic [1:0]        D_LEN_O,
  output logic [7:0]        D_CLASS_O,
  output logic [2:0]        D_SRC_O,
  output logic [1:0]        D_DST_O,
  output logic [7:0]        D_IMM_O,
  output logic [ADDR_W-1:0] D_ADDR_O
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  localparam logic [7:0] CLS_LOAD = 8'h01;
  localparam logic [7:0] CLS_ALU  = 8'h02;
  localparam logic [7:0] CLS_JUMP = 8'h04;
  localparam logic [7:0] CLS_CALL = 8'h08;
  localparam logic [7:0] CLS_RET  = 8'h10;
  localparam logic [7:0] CLS_RST  = 8'h20;
  localparam logic [7:0] CLS_IO   = 8'h40;
  localparam logic [7:0] CLS_HLT  = 8'h80;

  localparam logic [2:0] SRC_REG = 3'b001;
  localparam logic [2:0] SRC_MEM = 3'b010;
  localparam logic [2:0] SRC_IMM = 3'b100;
  localparam logic [1:0] DST_REG = 2'b01;
  localparam logic [1:0] DST_MEM = 2'b10;

  typedef enum logic [1:0] {ST_OPC, ST_B2, ST_B3} state_t;

  typedef struct packed {
    logic [7:0]        opc;
    logic [1:0]        len;
    logic [7:0]        cls;
    logic [2:0]        src;
    logic [1:0]        dst;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  state_t            state_q, state_d;
  logic [7:0]        opc_q;
  logic [7:0]        lo_q;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  entry_t            mem [DEPTH];

  logic       xfer, push, pop;
  logic [7:0] dec_opc;
  logic [1:0] dec_len;
  logic [7:0] dec_cls;
  logic [2:0] dec_src, sss_src;
  logic [1:0] dec_dst, ddd_dst;
  entry_t     push_ent, head;

  assign B_READY_O = (count < DEPTH_C) & ~FLUSH_I;
  assign xfer      = B_VALID_I & B_READY_O;
  assign D_VALID_O = (count != '0);
  assign pop       = D_VALID_O & D_READY_I & ~FLUSH_I;

  // Decode the opcode being accepted now (OPC state) or the one latched for
  // the instruction still being assembled. First matching rule wins.
  always_comb begin
    dec_opc = (state_q == ST_OPC) ? B_DATA_I : opc_q;
    sss_src = (dec_opc[2:0] == 3'b111) ? SRC_MEM : SRC_REG;
    ddd_dst = (dec_opc[5:3] == 3'b111) ? DST_MEM : DST_REG;
    dec_len = 2'd1;
    dec_cls = '0;
    dec_src = '0;
    dec_dst = '0;
    if ((dec_opc ==? 8'b0000_000?) || (dec_opc == 8'hFF)) begin
      dec_cls = CLS_HLT;
    end else if (dec_opc ==? 8'b11??_????) begin
      dec_cls = CLS_LOAD; dec_src = sss_src; dec_dst = ddd_dst;
    end else if (dec_opc ==? 8'b00??_?110) begin
      dec_cls = CLS_LOAD; dec_src = SRC_IMM; dec_dst = ddd_dst; dec_len = 2'd2;
    end else if (dec_opc ==? 8'b10??_????) begin
      dec_cls = CLS_ALU; dec_src = sss_src; dec_dst = DST_REG;
    end else if (dec_opc ==? 8'b00??_?100) begin
      dec_cls = CLS_ALU; dec_src = SRC_IMM; dec_dst = DST_REG; dec_len = 2'd2;
    end else if ((dec_opc ==? 8'b00??_?00?) || (dec_opc ==? 8'b000?_?010)) begin
      // INR/DCR and rotates operate on a register in place
      dec_cls = CLS_ALU; dec_src = SRC_REG; dec_dst = DST_REG;
    end else if ((dec_opc ==? 8'b00??_?011) || (dec_opc ==? 8'b00??_?111)) begin
      dec_cls = CLS_RET;
    end else if (dec_opc ==? 8'b00??_?101) begin
      dec_cls = CLS_RST;
    end else if ((dec_opc ==? 8'b01??_?100) || (dec_opc ==? 8'b01??_?000)) begin
      dec_cls = CLS_JUMP; dec_len = 2'd3;
    end else if ((dec_opc ==? 8'b01??_?110) || (dec_opc ==? 8'b01??_?010)) begin
      dec_cls = CLS_CALL; dec_len = 2'd3;
    end else if (dec_opc ==? 8'b01??_???1) begin
      dec_cls = CLS_IO;
    end
  end

  // Assembly FSM: push only on the final byte of an instruction.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_OPC: if (xfer) begin
        if (dec_len == 2'd1) push = 1'b1;
        else                 state_d = ST_B2;
      end
      ST_B2: if (xfer) begin
        if (dec_len == 2'd2) begin
          push    = 1'b1;
          state_d = ST_OPC;
        end else begin
          state_d = ST_B3;
        end
      end
      ST_B3: if (xfer) begin
        push    = 1'b1;
        state_d = ST_OPC;
      end
      default: state_d = ST_OPC;
    endcase
  end

  always_comb begin
    push_ent      = '0;
    push_ent.opc  = dec_opc;
    push_ent.len  = dec_len;
    push_ent.cls  = dec_cls;
    push_ent.src  = dec_src;
    push_ent.dst  = dec_dst;
    // A push from B2 can only be a 2-byte instruction, from B3 only a 3-byte one.
    push_ent.imm  = (state_q == ST_B2) ? B_DATA_I : 8'h00;
    push_ent.addr = (state_q == ST_B3) ? {B_DATA_I[ADDR_W-9:0], lo_q} : '0;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= ST_OPC;
      opc_q   <= '0;
      lo_q    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else if (FLUSH_I) begin
      state_q <= ST_OPC;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer && (state_q == ST_OPC)) opc_q <= B_DATA_I;
      if (xfer && (state_q == ST_B2))  lo_q  <= B_DATA_I;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only observable while count > 0.
  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  assign head      = D_VALID_O ? mem[rd_ptr] : '0;
  assign D_OPC_O   = head.opc;
  assign D_LEN_O   = head.len;
  assign D_CLASS_O = head.cls;
  assign D_SRC_O   = head.src;
  assign D_DST_O   = head.dst;
  assign D_IMM_O   = head.imm;
  assign D_ADDR_O  = head.addr;

endmodule
